if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the fetch PC, issues one-outstanding-request reads on the instruction SRAM-like bus and buffers the returned word. It presents {pc, pc+4, instruction, delay-slot flag} to the F/D pipeline register. It applies branch targets after the delay slot, and exception/ERET redirects immediately, cancelling any in-flight fetch.

## Interface
- RESET_PC, 32'hBFC0_0000, PC fetched after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallD  in  1  F/D register will not capture this cycle
- br_issue  in  1  pulse: a branch/jump is accepted into D this cycle
- br_taken  in  1  qualifies br_issue: branch taken / jump
- br_target  in  32  target, valid with br_issue && br_taken
- exc_redirect  in  1  pulse: exception/ERET flush, highest priority
- exc_pc  in  32  redirect address, valid with exc_redirect
- inst_req  out  1  read request
- inst_addr  out  32  request address (= pc_r)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- validF  out  1  outputs below hold a deliverable instruction
- pcF  out  32  PC of delivered instruction
- pc_plus4F  out  32  pcF + 4, modulo 2^32
- instrF  out  32  delivered instruction (0 when adelF)
- is_in_delayslotF  out  1  delivered instruction is a delay slot
- adelF  out  1  fetch address error (pcF[1:0] != 0)
- fetch_stall  out  1  = ~validF; decode inserts a bubble into D

## Operation
- State register, 4 states: REQ, WAIT, HOLD, DROP.
- REQ: inst_req=1. If pc_r[1:0]!=0: no request; load buffer with instr=0, adelF=1; go to HOLD. Else on inst_addr_ok go to WAIT.
- WAIT: on inst_data_ok capture inst_rdata into buffer; go to HOLD.
- HOLD: validF=1. Accept = validF && ~stallD. On accept, pc_r <= next_pc; go to REQ. Otherwise stay in HOLD and keep outputs stable.
- DROP: entered when a redirect lands during WAIT. The next inst_data_ok is discarded; then go to REQ.
- Delay-slot tracking:
  - br_issue sets ds_pend=1, tk_pend=br_taken, tgt_r=br_target.
  - is_in_delayslotF = ds_pend while validF.
  - On accept with ds_pend: next_pc = tk_pend ? tgt_r : pc_r+4; clear ds_pend and tk_pend. Otherwise next_pc = pc_r+4.
- exc_redirect, any state:
  - pc_r <= exc_pc; clear ds_pend, tk_pend and buffer valid.
  - From WAIT (or from REQ in the same cycle as inst_addr_ok): go to DROP. Otherwise go to REQ.
  - exc_redirect beats br_issue and accept in the same cycle.
- br_issue in the same cycle as accept of a non-delay-slot instruction: the accepted instruction uses pc+4; the pending flags apply to the following instruction.
- At most one request outstanding. inst_req is never asserted in WAIT or DROP.
- Arithmetic is 32-bit wrapping; 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - pc_r=RESET_PC, state=REQ, validF=0, instrF=0, pcF=RESET_PC, pc_plus4F=RESET_PC+4.
  - is_in_delayslotF=0, adelF=0, ds_pend=0, tk_pend=0.
  - inst_req=0 during the rst cycle.
- inst_req/inst_addr are combinational from state and pc_r. They hold stable until inst_addr_ok.
- Latency with addr_ok and data_ok both zero-wait: REQ (cycle 0), WAIT (cycle 1, data_ok), HOLD with validF (cycle 2). Throughput is 1 instruction per 3 cycles.
- A buffered instruction stays valid for any stallD duration; data is captured once, never re-fetched.
- rst mid-WAIT returns to REQ. The memory side is reset by the same rst, so no drop is needed.
- Redirect in HOLD: validF drops the next cycle and the stale instruction is never accepted.

## Test plan
- Reset, zero-wait memory, rdata=0x2408_0001: first inst_req with addr 0xBFC0_0000 the cycle after rst. validF=1, pcF=0xBFC0_0000, pc_plus4F=0xBFC0_0004 two cycles later. Next request to 0xBFC0_0004.
- stallD=1 for 5 cycles while in HOLD: pcF/instrF unchanged, inst_req=0. On release the next request is issued to pc+4.
- br_issue, br_taken=1, br_target=0xBFC0_0100 while D holds 0xBFC0_0008: 0xBFC0_000C is delivered with is_in_delayslotF=1. Next fetch is 0xBFC0_0100 with is_in_delayslotF=0. Repeat with br_taken=0: next fetch is 0xBFC0_0010.
- exc_redirect with exc_pc=0xBFC0_0380 during WAIT, data_ok 3 cycles later: the returned word is dropped. Next inst_addr=0xBFC0_0380. No validF before that fetch's data.
- exc_pc=0xBFC0_0382: no inst_req; validF=1, adelF=1, instrF=0, pcF=0xBFC0_0382.
- addr_ok delayed 4 cycles: inst_req and inst_addr stable throughout. Exactly one request counted by the bench monitor.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction SRAM-like read bus: one request/address handshake, one data beat per request.
interface if_fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // master = fetch unit, slave = instruction memory
  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one read outstanding, buffers the word
// for the F/D register and applies delayed-branch and exception redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stallD,
  input  logic                  i_br_issue,
  input  logic                  i_br_taken,
  input  logic [31:0]           i_br_target,
  input  logic                  i_exc_redirect,
  input  logic [31:0]           i_exc_pc,
  if_fetch_unit_if.master       bus,
  output logic                  o_validF,
  output logic [31:0]           o_pcF,
  output logic [31:0]           o_pc_plus4F,
  output logic [31:0]           o_instrF,
  output logic                  o_is_in_delayslotF,
  output logic                  o_adelF,
  output logic                  o_fetch_stall,
  output logic [1:0]            o_dbg_state
);

  // Bus handshake: a request is taken on a cycle where inst_req && inst_addr_ok; its single
  // data beat arrives on a later cycle with inst_data_ok. inst_req/inst_addr stay stable until taken.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_pcF;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_adel;
  logic        r_ds_pend;
  logic        r_tk_pend;

  logic        w_aligned;
  logic        w_req;
  logic        w_addr_hs;
  logic        w_accept;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_req      = ~rst && (r_state == S_REQ) && w_aligned;
  assign w_addr_hs  = w_req && bus.inst_addr_ok;
  assign w_accept   = r_valid && ~i_stallD;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_next_pc  = (r_ds_pend && r_tk_pend) ? r_tgt : w_pc_plus4;

  assign bus.inst_req  = w_req;
  assign bus.inst_addr = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_tgt     <= '0;
      r_pcF     <= RESET_PC;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_adel    <= 1'b0;
      r_ds_pend <= 1'b0;
      r_tk_pend <= 1'b0;
    end else if (i_exc_redirect) begin
      r_pc      <= i_exc_pc;
      r_valid   <= 1'b0;
      r_ds_pend <= 1'b0;
      r_tk_pend <= 1'b0;
      // A reply still owed by the bus must be swallowed; one arriving right now is already gone.
      if (w_addr_hs || ((r_state == S_WAIT || r_state == S_DROP) && !bus.inst_data_ok))
        r_state <= S_DROP;
      else
        r_state <= S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!w_aligned) begin
            r_instr <= '0;
            r_adel  <= 1'b1;
            r_pcF   <= r_pc;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if (w_addr_hs) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            r_instr <= bus.inst_rdata;
            r_adel  <= 1'b0;
            r_pcF   <= r_pc;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_pc      <= w_next_pc;
            r_valid   <= 1'b0;
            r_ds_pend <= 1'b0;
            r_tk_pend <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.inst_data_ok) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
      // Placed after the accept clear so a branch accepted now marks the following instruction.
      if (i_br_issue) begin
        r_ds_pend <= 1'b1;
        r_tk_pend <= i_br_taken;
        r_tgt     <= i_br_target;
      end
    end
  end

  assign o_validF           = r_valid;
  assign o_pcF              = r_pcF;
  assign o_pc_plus4F        = r_pcF + 32'd4;
  assign o_instrF           = r_instr;
  assign o_is_in_delayslotF = r_ds_pend && r_valid;
  assign o_adelF            = r_adel;
  assign o_fetch_stall      = ~r_valid;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small instruction-memory responder model.
module tb_if_fetch_unit;
  logic        clk;
  logic        rst;
  logic        stallD, br_issue, br_taken, exc_redirect;
  logic [31:0] br_target, exc_pc;
  logic        validF, is_ds, adelF, fetch_stall;
  logic [31:0] pcF, pc_plus4F, instrF;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .i_stallD(stallD), .i_br_issue(br_issue), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_exc_redirect(exc_redirect), .i_exc_pc(exc_pc), .bus(bus),
    .o_validF(validF), .o_pcF(pcF), .o_pc_plus4F(pc_plus4F), .o_instrF(instrF),
    .o_is_in_delayslotF(is_ds), .o_adelF(adelF), .o_fetch_stall(fetch_stall), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instruction memory model: word content derived from address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9BC8_0001;
  endfunction

  logic        addr_ok_d = 1'b0, data_ok_d = 1'b0;
  logic [31:0] rdata_d = '0, pend_addr = '0;
  bit          pend = 0;
  int          a_cnt = 0, d_cnt = 0, addr_wait = 0, data_wait = 0, req_accepts = 0;

  assign bus.inst_addr_ok = addr_ok_d;
  assign bus.inst_data_ok = data_ok_d;
  assign bus.inst_rdata   = rdata_d;

  // decides the bus responses seen at the next rising edge
  always @(negedge clk) begin
    #1;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    if (rst) begin
      pend = 0; a_cnt = 0; d_cnt = 0;
    end else if (pend) begin
      if (d_cnt >= data_wait) begin
        data_ok_d = 1'b1; rdata_d = mem_word(pend_addr); pend = 0;
      end else d_cnt++;
    end else if (bus.inst_req) begin
      if (a_cnt >= addr_wait) begin
        addr_ok_d = 1'b1; pend = 1; pend_addr = bus.inst_addr; d_cnt = 0; a_cnt = 0; req_accepts++;
      end else a_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (validF) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stallD = 1'b0; br_issue = 1'b0; br_taken = 1'b0; br_target = '0;
    exc_redirect = 1'b0; exc_pc = '0;
    tick(); tick();
    total++; if (validF !== 1'b0) begin bad++; $display("FAIL rst_validF: got %b exp 0", validF); end
    total++; if (pcF !== 32'hBFC0_0000) begin bad++; $display("FAIL rst_pcF: got %h exp bfc00000", pcF); end
    total++; if (pc_plus4F !== 32'hBFC0_0004) begin bad++; $display("FAIL rst_pc4: got %h exp bfc00004", pc_plus4F); end
    total++; if (instrF !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h exp 0", instrF); end
    total++; if ({is_ds, adelF, fetch_stall} !== 3'b001) begin bad++; $display("FAIL rst_flags: got %b exp 001", {is_ds, adelF, fetch_stall}); end
    total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b exp 0", bus.inst_req); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_zero_wait();
    rst = 1'b0;
    #2;
    total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL first_req: got req=%b addr=%h exp 1 bfc00000", bus.inst_req, bus.inst_addr); end
    tick();
    total++; if (validF !== 1'b0 || bus.inst_req !== 1'b0) begin bad++; $display("FAIL wait_cycle: got valid=%b req=%b exp 0 0", validF, bus.inst_req); end
    tick();
    total++; if (validF !== 1'b1 || pcF !== 32'hBFC0_0000 || pc_plus4F !== 32'hBFC0_0004) begin bad++; $display("FAIL first_deliver: got v=%b pc=%h pc4=%h exp 1 bfc00000 bfc00004", validF, pcF, pc_plus4F); end
    total++; if (instrF !== 32'h2408_0001 || fetch_stall !== 1'b0) begin bad++; $display("FAIL first_instr: got %h stall=%b exp 24080001 0", instrF, fetch_stall); end
    tick();
    total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL second_req: got req=%b addr=%h exp 1 bfc00004", bus.inst_req, bus.inst_addr); end
    stallD = 1'b1;
  endtask

  task automatic test_stall();
    bit ok;
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0004) begin bad++; $display("FAIL stall_first: got ok=%b pc=%h exp 1 bfc00004", ok, pcF); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (validF !== 1'b1 || pcF !== 32'hBFC0_0004 || instrF !== mem_word(32'hBFC0_0004) || bus.inst_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h req=%b exp 1 bfc00004 %h 0", i, validF, pcF, instrF, bus.inst_req, mem_word(32'hBFC0_0004));
      end
    end
    stallD = 1'b0;
    tick();
    total++; if (validF !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0008) begin bad++; $display("FAIL stall_release: got v=%b req=%b addr=%h exp 0 1 bfc00008", validF, bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_branch();
    bit ok;
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0008 || is_ds !== 1'b0) begin bad++; $display("FAIL br_pre: got ok=%b pc=%h ds=%b exp 1 bfc00008 0", ok, pcF, is_ds); end
    br_issue = 1'b1; br_taken = 1'b1; br_target = 32'hBFC0_0100;
    tick();
    br_issue = 1'b0; br_target = 32'h0;
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_000C || is_ds !== 1'b1) begin bad++; $display("FAIL br_slot: got ok=%b pc=%h ds=%b exp 1 bfc0000c 1", ok, pcF, is_ds); end
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0100 || is_ds !== 1'b0 || instrF !== mem_word(32'hBFC0_0100)) begin bad++; $display("FAIL br_target: got ok=%b pc=%h ds=%b instr=%h exp 1 bfc00100 0", ok, pcF, is_ds, instrF); end
    br_issue = 1'b1; br_taken = 1'b0; br_target = 32'hBFC0_0200;
    tick();
    br_issue = 1'b0;
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0104 || is_ds !== 1'b1) begin bad++; $display("FAIL nt_slot: got ok=%b pc=%h ds=%b exp 1 bfc00104 1", ok, pcF, is_ds); end
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0108 || is_ds !== 1'b0) begin bad++; $display("FAIL nt_next: got ok=%b pc=%h ds=%b exp 1 bfc00108 0", ok, pcF, is_ds); end
  endtask

  task automatic test_exc_drop();
    bit ok, seen;
    data_wait = 3;
    tick();
    total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_010C) begin bad++; $display("FAIL drop_req: got req=%b addr=%h exp 1 bfc0010c", bus.inst_req, bus.inst_addr); end
    tick();
    total++; if (bus.inst_req !== 1'b0 || validF !== 1'b0 || dbg_state !== 2'd1) begin bad++; $display("FAIL drop_inwait: got req=%b v=%b st=%0d exp 0 0 1", bus.inst_req, validF, dbg_state); end
    exc_redirect = 1'b1; exc_pc = 32'hBFC0_0380;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exc_redirect = 1'b0;
      total++; if (validF !== 1'b0) begin bad++; $display("FAIL drop_novalid%0d: got %b exp 0", i, validF); end
      if (bus.inst_req) begin seen = 1; break; end
    end
    data_wait = 0;
    total++; if (!seen || bus.inst_addr !== 32'hBFC0_0380) begin bad++; $display("FAIL drop_newreq: got seen=%b addr=%h exp 1 bfc00380", seen, bus.inst_addr); end
    wait_valid(12, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0380 || instrF !== mem_word(32'hBFC0_0380)) begin bad++; $display("FAIL drop_deliver: got ok=%b pc=%h instr=%h exp 1 bfc00380 %h", ok, pcF, instrF, mem_word(32'hBFC0_0380)); end
  endtask

  task automatic test_adel_wrap();
    bit ok;
    int req0;
    req0 = req_accepts;
    exc_redirect = 1'b1; exc_pc = 32'hBFC0_0382; stallD = 1'b1;
    tick();
    exc_redirect = 1'b0;
    total++; if (validF !== 1'b0 || bus.inst_req !== 1'b0) begin bad++; $display("FAIL adel_redirect: got v=%b req=%b exp 0 0", validF, bus.inst_req); end
    tick();
    total++; if (validF !== 1'b1 || adelF !== 1'b1 || instrF !== 32'h0) begin bad++; $display("FAIL adel_flags: got v=%b adel=%b instr=%h exp 1 1 0", validF, adelF, instrF); end
    total++; if (pcF !== 32'hBFC0_0382 || pc_plus4F !== 32'hBFC0_0386) begin bad++; $display("FAIL adel_pc: got %h %h exp bfc00382 bfc00386", pcF, pc_plus4F); end
    total++; if (req_accepts !== req0) begin bad++; $display("FAIL adel_noreq: got %0d requests exp %0d", req_accepts, req0); end
    exc_redirect = 1'b1; exc_pc = 32'hFFFF_FFFC;
    tick();
    exc_redirect = 1'b0; stallD = 1'b0;
    total++; if (validF !== 1'b0) begin bad++; $display("FAIL hold_redirect: got v=%b exp 0", validF); end
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hFFFF_FFFC || pc_plus4F !== 32'h0 || adelF !== 1'b0) begin bad++; $display("FAIL wrap_deliver: got ok=%b pc=%h pc4=%h adel=%b exp 1 fffffffc 0 0", ok, pcF, pc_plus4F, adelF); end
    addr_wait = 4;
  endtask

  task automatic test_addr_delay();
    bit ok;
    int req0;
    req0 = req_accepts;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0) begin bad++; $display("FAIL delay_stable%0d: got req=%b addr=%h exp 1 0", i, bus.inst_req, bus.inst_addr); end
    end
    tick();
    addr_wait = 0;
    total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL delay_taken: got req=%b exp 0", bus.inst_req); end
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'h0 || instrF !== mem_word(32'h0)) begin bad++; $display("FAIL delay_deliver: got ok=%b pc=%h instr=%h exp 1 0 %h", ok, pcF, instrF, mem_word(32'h0)); end
    total++; if (req_accepts - req0 !== 1) begin bad++; $display("FAIL delay_count: got %0d exp 1", req_accepts - req0); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    data_wait = 5;
    tick();
    tick();
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL midrst_wait: got st=%0d exp 1", dbg_state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_wait = 0;
    #2;
    total++; if (validF !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL midrst_req: got v=%b req=%b addr=%h exp 0 1 bfc00000", validF, bus.inst_req, bus.inst_addr); end
    wait_valid(10, ok);
    total++; if (!ok || pcF !== 32'hBFC0_0000 || instrF !== 32'h2408_0001) begin bad++; $display("FAIL midrst_deliver: got ok=%b pc=%h instr=%h exp 1 bfc00000 24080001", ok, pcF, instrF); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch();
    test_exc_drop();
    test_adel_wrap();
    test_addr_delay();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
